// File: rtl/seq_det_pkg.sv
// Shared constants, length type and the pattern-length clamp for the
// parametrised serial pattern detector.
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam logic [7:0] DEF_PAT = 8'b0000_1101;
  localparam int DEF_LEN = 4;

  localparam int LEN_W_DEF = $clog2(PAT_W_DEF + 1);
  typedef logic [LEN_W_DEF-1:0] len_t;

  // A pattern shorter than two bits is meaningless; longer than the history is impossible.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len < 2) begin
      return 2;
    end
    if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial data, pattern-load controls and match outputs of the detector,
// grouped so the driver and the detector share one bundle.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  // Din is a bit of the stream only in a cycle where Din_valid is high;
  // there is no back-pressure, the detector takes every qualified bit.
  logic             Din;
  logic             Din_valid;
  logic             Load;
  logic [PAT_W-1:0] Pat;
  logic [LEN_W-1:0] Pat_len;
  logic             Overlap;
  logic             Y;
  logic [CNT_W-1:0] Match_cnt;

  modport master (
    output Din,
    output Din_valid,
    output Load,
    output Pat,
    output Pat_len,
    output Overlap,
    input  Y,
    input  Match_cnt
  );

  modport slave (
    input  Din,
    input  Din_valid,
    input  Load,
    input  Pat,
    input  Pat_len,
    input  Overlap,
    output Y,
    output Match_cnt
  );

endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter: async reset, synchronous clear, increment enable.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and a
// saturating match counter. Define SEQDET_MOORE_OUT_EN for a registered Y.
module seq_detector_param #(
  parameter int                 PAT_W   = seq_det_pkg::PAT_W_DEF,
  parameter int                 CNT_W   = seq_det_pkg::CNT_W_DEF,
  parameter logic [PAT_W-1:0]   DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
  parameter int                 DEF_LEN = seq_det_pkg::DEF_LEN
) (
  input  logic                 Clk,
  input  logic                 Rst,
  seq_detector_param_if.slave  bus
);

  import seq_det_pkg::*;

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(clamp_len(32'(DEF_LEN), 32'(PAT_W)));
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  // The oldest history bit can never reach the comparator (len <= PAT_W
  // and Din supplies the newest bit), so only PAT_W-1 bits are stored.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] window;
  logic             accept;
  logic             fill_ok;
  logic             bits_eq;
  logic             match;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign window  = {hist_q, bus.Din};
  assign accept  = bus.Din_valid & ~bus.Load;
  assign fill_ok = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign bits_eq = ((window ^ pat_q) & mask) == '0;
  assign match   = accept & fill_ok & bits_eq;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    len_d  = len_q;
    pat_d  = pat_q;
    if (bus.Load) begin
      pat_d  = bus.Pat;
      len_d  = LEN_W'(clamp_len(32'(bus.Pat_len), 32'(PAT_W)));
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      if (match && !bus.Overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hist_q <= '0;
      fill_q <= '0;
      len_q  <= LEN_RST;
      pat_q  <= DEF_PAT;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      len_q  <= len_d;
      pat_q  <= pat_d;
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i (Clk),
    .rst_i (Rst),
    .clr_i (bus.Load),
    .inc_i (match),
    .cnt_o (bus.Match_cnt)
  );

`ifdef SEQDET_MOORE_OUT_EN
  // match is already low in a Load cycle, so Load also clears the flag.
  logic y_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      y_q <= 1'b0;
    end else begin
      y_q <= match;
    end
  end

  assign bus.Y = y_q;
`else
  assign bus.Y = match;
`endif

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector, successor to the fixed 1101 Mealy detector.
- Pattern and length are runtime-loadable, up to PAT_W bits.
- Overlapping and non-overlapping detection, selected at runtime.
- Qualified input stream via a valid strobe.
- Saturating match counter.
- Sits on a serial data path and flags framing/sync words to downstream control logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (2..16).
- CNT_W, 8, match counter width.
- DEF_PAT, 8'b0000_1101, pattern loaded at reset, right-aligned (LSB = last bit received).
- DEF_LEN, 4, pattern length loaded at reset.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Din  input  1  serial data bit.
- Din_valid  input  1  Din is sampled only when high.
- Load  input  1  capture Pat/Pat_len on this edge.
- Pat  input  PAT_W  new pattern, right-aligned.
- Pat_len  input  $clog2(PAT_W+1)  new pattern length.
- Overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- Y  output  1  match flag (Mealy: same cycle as the completing bit).
- Match_cnt  output  CNT_W  number of matches since reset/load, saturating.

Behaviour:
- Reset (async, immediate): hist=0, fill=0, pat_r=DEF_PAT, len_r=DEF_LEN, Match_cnt=0, Y=0.
- State:
  - hist: PAT_W-bit history of valid bits, newest in LSB.
  - fill: count of valid bits held, saturating at PAT_W.
- Accept: on a rising edge with Din_valid=1 and Load=0, hist <= {hist[PAT_W-2:0],Din} and fill <= min(fill+1,PAT_W). Din_valid=0 leaves all state unchanged; gaps are transparent.
- Match (combinational): Y = Din_valid & ~Load & (fill >= len_r-1) & ({hist,Din}[len_r-1:0] == pat_r[len_r-1:0]). Only the low len_r bits are compared; upper pattern bits are don't-care.
- On a match edge:
  - Match_cnt increments, holding at 2^CNT_W-1 (no wrap).
  - Overlap=1: history is kept, so a suffix of the match can start the next match.
  - Overlap=0: hist <= 0 and fill <= 0, so the next match needs len_r fresh bits.
- Load edge:
  - pat_r <= Pat.
  - len_r <= clamp(Pat_len): 0 or 1 -> 2; >PAT_W -> PAT_W.
  - hist, fill and Match_cnt are cleared.
  - Y=0 during the Load cycle, and Din is discarded that cycle.
- Overlap may change at any time. It takes effect on the next match edge and does not retro-clear history.
- Reset mid-stream: a partial match is lost; the first match after reset needs len_r new valid bits.
- No X-propagation: outputs are defined whenever Rst has been asserted once.

Optional Feature:
SEQDET_MOORE_OUT_EN
- Defined:
  - Y is registered (Moore-style) and asserts one cycle after the completing bit, for exactly one cycle.
  - Match_cnt timing is unchanged.
  - Y is cleared by Rst and by Load.
- Undefined: Y is the combinational Mealy output described above.

Decomposition:
- Package seq_det_pkg holds:
  - PAT_W/CNT_W defaults, DEF_PAT, DEF_LEN.
  - len_t typedef ($clog2(PAT_W+1) bits).
  - the length-clamp function.
- One natural sub-module: seq_det_sat_cnt, a CNT_W saturating counter with sync clear (Load), async reset (Rst) and increment enable.
- Comparator and history stay in the top module.

Test Plan:
- Default pattern 1101, Overlap=1, after reset feed 0,1,0,1,0,1,1,1,0,1,0,1,0,1 (one bit per negedge, Din_valid=1) -> Y high only on the 10th bit; Match_cnt=1.
- Default pattern, stream 1,1,0,1,1,0,1:
  - Overlap=1 -> Y on bits 4 and 7, Match_cnt=2.
  - Overlap=0 -> Y on bit 4 only, Match_cnt=1.
- Load Pat=8'b101, Pat_len=3, Overlap=1, then stream 1,0,1,0,1 -> Y on bits 3 and 5, Match_cnt=2; Y=0 during the Load cycle.
- Valid gaps: stream 1,1,(Din_valid=0 with Din=1 for 3 cycles),0,1 -> Y on final bit, Match_cnt=1.
- Reset mid-operation: feed 1,1,0, pulse Rst for half a clock, then 1 -> Y stays 0, Match_cnt=0; then feed 1,1,0,1 -> Y on the 4th bit.
- Saturation: CNT_W=2, Overlap=1, stream 1101 followed by 101 repeated 5 times (6 matches) -> Match_cnt reaches 3 and holds; Y still pulses on every match.
